// File: rtl/online_digit_loader.sv
// Accepts signed-digit pairs (x, y) over a valid/ready handshake and replays them
// one per cycle as write strobes, with nibble and word addressing, to a packing RAM stage.
module online_digit_loader #(
    parameter int unsigned MAX_WORDS = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] num_words,
    input  logic       in_valid,
    input  logic [1:0] x_digit,
    input  logic [1:0] y_digit,
    output logic       in_ready,
    output logic [1:0] x_input,
    output logic [1:0] y_input,
    output logic       we,
    output logic [8:0] cnt,
    output logic [6:0] computation_cycles,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam logic [6:0] MAX_W7 = 7'(MAX_WORDS);

    state_t     state_q, state_d;
    logic [8:0] total_q, total_d;
    logic [8:0] acc_q, acc_d;
    logic [8:0] cnt_q, cnt_d;
    logic [1:0] x_q, x_d;
    logic [1:0] y_q, y_d;
    logic       we_q, we_d;
    logic       err_q, err_d;
    logic [6:0] words_clamped;

    // Digit code 11 is not a valid signed digit; it is passed on as zero.
    function automatic logic [1:0] legal_digit(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    assign words_clamped = (num_words > MAX_W7) ? MAX_W7 : num_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            total_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start && (num_words != 7'd0)) begin
                    state_d = LOAD;
                    total_d = {words_clamped, 2'b00};
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    x_d   = legal_digit(x_digit);
                    y_d   = legal_digit(y_digit);
                    cnt_d = acc_q;
                    we_d  = 1'b1;
                    acc_d = acc_q + 9'd1;
                    if ((x_digit == 2'b11) || (y_digit == 2'b11)) begin
                        err_d = 1'b1;
                    end
                    // The final write is still in flight; DRAIN carries it out.
                    if ((acc_q + 9'd1) == total_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready           = (state_q == LOAD);
    assign busy               = (state_q == LOAD) || (state_q == DRAIN);
    assign done               = (state_q == DONE);
    assign we                 = we_q;
    assign cnt                = cnt_q;
    assign computation_cycles = cnt_q[8:2];
    assign x_input            = x_q;
    assign y_input            = y_q;
    assign err                = err_q;

endmodule
